// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice.
// Contents:
//   alu_op_e : names for the eight 3-bit operation encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor for ADD and SUB. Purely combinational.
// Ports:
//   A, B     : operands (WIDTH bits)
//   sub      : 0 = A+B, 1 = A-B
//   sum      : result modulo 2^WIDTH
//   carry    : carry-out for add, borrow (A < B unsigned) for subtract
//   overflow : two's-complement overflow of the selected operation
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   full_s;

  // Subtraction is A + ~B + 1, so one adder serves both operations.
  assign b_eff_s = sub ? ~B : B;
  assign full_s  = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
  assign sum     = full_s[WIDTH-1:0];

  // In subtract mode the raw carry-out is the inverse of the borrow.
  assign carry   = sub ? ~full_s[WIDTH] : full_s[WIDTH];

  // Overflow when the effective addends agree in sign but the sum does not.
  assign overflow = (A[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU: eight operations selected by OpCode. The result and flags
// are captured one cycle after the inputs; a new op can be issued every cycle.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   A, B       : operands (WIDTH bits, WIDTH >= 2)
//   OpCode     : operation select (see alu_pkg::alu_op_e)
//   res        : registered result
//   carry      : registered carry / borrow (ADD, SUB only; else 0)
//   overflow   : registered two's-complement overflow (ADD, SUB only; else 0)
//   zero       : registered flag, res == 0
//   neg        : registered flag, res MSB
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OpCode,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  alu_op_e          op_s;
  logic             sub_s;
  logic [WIDTH-1:0] sum_s;
  logic             as_carry_s;
  logic             as_ovf_s;
  logic             slt_s;

  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic             zero_s;
  logic             neg_s;

  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  assign op_s  = alu_op_e'(OpCode);
  assign sub_s = (op_s == OP_SUB);
  assign slt_s = ($signed(A) < $signed(B));

  alu_addsub #(
    .WIDTH    (WIDTH)
  ) u_addsub (
    .A        (A),
    .B        (B),
    .sub      (sub_s),
    .sum      (sum_s),
    .carry    (as_carry_s),
    .overflow (as_ovf_s)
  );

  // Next-cycle result and arithmetic flags selected by operation.
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB: begin
        res_s   = sum_s;
        carry_s = as_carry_s;
        ovf_s   = as_ovf_s;
      end
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_XOR:  res_s = A ^ B;
      // Shifted-out bits are dropped; carry stays 0.
      OP_SHL:  res_s = {A[WIDTH-2:0], 1'b0};
      OP_SHR:  res_s = {1'b0, A[WIDTH-1:1]};
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
      default: res_s = '0;
    endcase
  end

  assign zero_s = (res_s == '0);
  assign neg_s  = res_s[WIDTH-1];

  // Output registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      res_r   <= res_s;
      carry_r <= carry_s;
      ovf_r   <= ovf_s;
      zero_r  <= zero_s;
      neg_r   <= neg_s;
    end
  end

  assign res      = res_r;
  assign carry    = carry_r;
  assign overflow = ovf_r;
  assign zero     = zero_r;
  assign neg      = neg_r;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: one WIDTH=4 and one WIDTH=6 instance driven side by side.
// Expected values come from an integer-arithmetic model of the operations.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] a4, b4;
  logic [2:0] op4;
  logic [5:0] a6, b6;
  logic [2:0] op6;

  logic [3:0] res4;
  logic       c4, v4, z4, n4;
  logic [5:0] res6;
  logic       c6, v6, z6, n6;

  int total;
  int passed;
  int fails;

  alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .OpCode(op4),
    .res(res4), .carry(c4), .overflow(v4), .zero(z4), .neg(n4)
  );

  alu #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .A(a6), .B(b6), .OpCode(op6),
    .res(res6), .carry(c6), .overflow(v6), .zero(z6), .neg(n6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {res (zero-extended to 8 bits), carry, overflow, zero, neg}.
  function automatic logic [11:0] model(input int w, input int a, input int b, input int op);
    int m, h, sa, sb, r, t;
    logic c, v;
    logic [7:0] r8;
    m  = 1 << w;
    h  = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      0: begin
        t = a + b;   r = t % m;      c = (t >= m);
        t = sa + sb; v = (t >= h) || (t < -h);
      end
      1: begin
        r = (a - b + m) % m;         c = (a < b);
        t = sa - sb; v = (t >= h) || (t < -h);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * 2) % m;
      6: r = a / 2;
      7: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    r8 = r[7:0];
    return {r8, c, v, (r == 0), (r >= h)};
  endfunction

  function automatic logic [11:0] got4();
    return {4'b0000, res4, c4, v4, z4, n4};
  endfunction

  function automatic logic [11:0] got6();
    return {2'b00, res6, c6, v6, z6, n6};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive both instances at the falling edge, then check one cycle later.
  task automatic step(input string tag,
                      input logic [3:0] a4_v, input logic [3:0] b4_v, input logic [2:0] op4_v,
                      input logic [5:0] a6_v, input logic [5:0] b6_v, input logic [2:0] op6_v);
    logic [11:0] e4, e6;
    @(negedge clk);
    a4 = a4_v; b4 = b4_v; op4 = op4_v;
    a6 = a6_v; b6 = b6_v; op6 = op6_v;
    e4 = model(4, int'(a4_v), int'(b4_v), int'(op4_v));
    e6 = model(6, int'(a6_v), int'(b6_v), int'(op6_v));
    @(posedge clk);
    #1;
    check({tag, "/w4"}, got4(), e4);
    check({tag, "/w6"}, got6(), e6);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b0;
    a4 = 4'd0; b4 = 4'd0; op4 = 3'd0;
    a6 = 6'd0; b6 = 6'd0; op6 = 3'd0;

    #2;
    check("reset_w4", got4(), 12'h000);
    check("reset_w6", got6(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Worked examples, with literal expectations alongside the model.
    step("add_15_1", 4'd15, 4'd1, 3'b000, 6'd24, 6'd3, 3'b000);
    check("lit_add_15_1", got4(), {8'd0, 4'b1010});
    check("lit_add_24_3", got6(), {8'd27, 4'b0000});
    step("add_4_4",   4'd4, 4'd4, 3'b000, 6'd31, 6'd1, 3'b000);
    check("lit_add_4_4", got4(), {8'd8, 4'b0101});
    step("sub_5_5",   4'd5, 4'd5, 3'b001, 6'd32, 6'd1, 3'b001);
    check("lit_sub_5_5", got4(), {8'd0, 4'b0010});
    step("sub_2_3",   4'd2, 4'd3, 3'b001, 6'd0, 6'd63, 3'b001);
    check("lit_sub_2_3", got4(), {8'd15, 4'b1001});
    step("and",  4'b1010, 4'b1100, 3'b010, 6'h2a, 6'h33, 3'b010);
    check("lit_and", got4(), {8'd8, 4'b0001});
    step("or",   4'b1010, 4'b1100, 3'b011, 6'h2a, 6'h33, 3'b011);
    check("lit_or", got4(), {8'd14, 4'b0001});
    step("xor",  4'b1010, 4'b1100, 3'b100, 6'h2a, 6'h33, 3'b100);
    check("lit_xor", got4(), {8'd6, 4'b0000});
    step("shl",  4'b1010, 4'b1100, 3'b101, 6'h21, 6'h00, 3'b101);
    check("lit_shl", got4(), {8'd4, 4'b0000});
    step("shr",  4'b1010, 4'b1100, 3'b110, 6'h21, 6'h3f, 3'b110);
    check("lit_shr", got4(), {8'd5, 4'b0000});
    step("slt_3_2",   4'd3, 4'd2, 3'b111, 6'd40, 6'd5, 3'b111);
    check("lit_slt_3_2", got4(), {8'd0, 4'b0010});
    step("slt_8_1",   4'b1000, 4'b0001, 3'b111, 6'd5, 6'd40, 3'b111);
    check("lit_slt_8_1", got4(), {8'd1, 4'b0000});

    // Asynchronous reset between edges with nonzero outputs held.
    step("pre_reset", 4'd7, 4'd6, 3'b000, 6'd50, 6'd9, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_w4", got4(), 12'h000);
    check("async_reset_w6", got6(), 12'h000);
    rst_n = 1'b1;
    #0.5;
    check("released_no_edge_w4", got4(), 12'h000);
    step("post_reset", 4'd9, 4'd9, 3'b000, 6'd33, 6'd31, 3'b001);

    // Random operations on both widths, back-to-back.
    for (int i = 0; i < 60; i++) begin
      step("rand",
           4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)),
           6'($urandom_range(63)), 6'($urandom_range(63)), 3'($urandom_range(7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, minimum 2: operand and result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 OpCode  input  3  operation select.
REQ-007 res  output  WIDTH  registered result.
REQ-008 carry  output  1  registered carry-out / borrow flag.
REQ-009 overflow  output  1  registered two's-complement overflow flag.
REQ-010 zero  output  1  registered flag, 1 when res is all zeros.
REQ-011 neg  output  1  registered flag, equal to res[WIDTH-1].

Function
REQ-012 Combinational result and flags SHALL be computed from A, B and OpCode, then captured into the output registers on every rising clk edge; latency exactly 1 cycle, no handshake, new op accepted every cycle.
REQ-013 OpCode 000 ADD: res = (A+B) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum; overflow = 1 when A and B have equal MSBs and res MSB differs.
REQ-014 OpCode 001 SUB: res = (A-B) mod 2^WIDTH; carry = borrow, 1 iff A < B unsigned; overflow = 1 when A and B MSBs differ and res MSB differs from A MSB.
REQ-015 OpCode 010 AND: res = A & B.
REQ-016 OpCode 011 OR: res = A | B.
REQ-017 OpCode 100 XOR: res = A ^ B.
REQ-018 OpCode 101 SHL: res = A shifted left by one, LSB filled with 0; B ignored.
REQ-019 OpCode 110 SHR: res = A shifted right logically by one, MSB filled with 0; B ignored.
REQ-020 OpCode 111 SLT: res = 1 (zero-extended) when A < B as signed two's-complement, else 0.
REQ-021 For opcodes 010-111, carry and overflow SHALL be 0 (shifted-out bits are discarded, not reported).
REQ-022 zero and neg SHALL be derived from the same-cycle result for every opcode.
REQ-023 Wrap-around: ADD/SUB results wrap modulo 2^WIDTH with no saturation.
REQ-024 Any X/undefined OpCode SHALL not occur; all 8 encodings are defined, no default-case fallthrough needed.

Reset
REQ-025 While rst_n = 0, res, carry, overflow, zero and neg SHALL be 0, immediately and independent of clk.
REQ-026 Reset deassertion mid-stream: first rising edge with rst_n = 1 captures the current inputs; no extra latency.

Structure
REQ-027 Opcode encodings SHALL be named constants in shared package alu_pkg.
REQ-028 Adder/subtractor SHALL be one sub-module alu_addsub (WIDTH, A, B, sub -> sum, carry/borrow, overflow); logic, shift, compare and flag registers live in alu.

Verification
REQ-029 WIDTH=6: A=24, B=3, ADD -> next cycle res=27, C=0, V=0, Z=0, N=0.
REQ-030 WIDTH=4: A=15, B=1, ADD -> res=0, C=1, V=0, Z=1; A=4, B=4, ADD -> res=1000, C=0, V=1, N=1.
REQ-031 WIDTH=4: A=5, B=5, SUB -> res=0, C=0, V=0, Z=1; A=2, B=3, SUB -> res=1111, C=1, N=1.
REQ-032 WIDTH=4: A=1010, B=1100: AND -> 1000 N=1; OR -> 1110 N=1; XOR -> 0110; SHL(A) -> 0100 C=0; SHR(A) -> 0101; all C=V=0.
REQ-033 WIDTH=4: SLT A=3, B=2 -> res=0, Z=1; SLT A=1000, B=0001 -> res=0001.
REQ-034 Assert rst_n=0 asynchronously between edges with nonzero outputs -> all outputs 0 immediately; release, next edge captures inputs.
